fetch_unit: RTL and testbench

Instruction-fetch stage for the pipelined MIPS core: owns the program counter, drives instruction memory through a req/ready handshake, and loads the IF/ID register. It consumes the redirect controls produced by the jump unit: `i_pc_src` selects the next PC and `i_kill1` invalidates IF/ID. It also honours the hazard unit's stall and discards in-flight fetches that a redirect has made stale.

---
 rtl/fetch_unit.sv | 139 +++++++++++++
 tb/tb_fetch_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives instruction memory over a
// req/ready handshake, and loads the IF/ID register under redirect/kill/stall.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_pc_src,
  input  logic        i_kill1,
  input  logic [31:0] i_jump_target,
  input  logic [31:0] i_branch_target,
  input  logic        i_stall,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic [31:0] i_imem_data,
  output logic [31:0] o_ifid_instr,
  output logic [31:0] o_ifid_pc4,
  output logic        o_ifid_valid
);

  typedef enum logic [1:0] {BOOT, FETCH, DROP, HOLD} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] pend, pend_n;
  logic [31:0] hold, hold_n;
  logic [31:0] instr_n, pc4_n;
  logic        valid_n;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  assign redirect = (i_pc_src != 2'b00);
  assign target   = ((i_pc_src == 2'b01) ? i_jump_target : i_branch_target) & 32'hFFFF_FFFC;
  assign pc_plus4 = pc + 32'd4;

  // Request and address depend on state and pc only.
  assign o_imem_req  = (state == FETCH) || (state == DROP);
  assign o_imem_addr = pc;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    pend_n  = pend;
    hold_n  = hold;
    instr_n = o_ifid_instr;
    pc4_n   = o_ifid_pc4;
    valid_n = o_ifid_valid;
    case (state)
      BOOT: begin
        state_n = FETCH;
      end
      FETCH: begin
        if (redirect) begin
          valid_n = 1'b0;
          if (i_imem_ready) begin
            pc_n = target;
          end else begin
            pend_n  = target;
            state_n = DROP;
          end
        end else if (i_imem_ready) begin
          if (!i_stall) begin
            instr_n = i_imem_data;
            pc4_n   = pc_plus4;
            valid_n = 1'b1;
            pc_n    = pc_plus4;
          end else begin
            hold_n  = i_imem_data;
            state_n = HOLD;
          end
        end else begin
          state_n = FETCH;
        end
      end
      DROP: begin
        // The stale transfer must finish before the latest target is issued.
        valid_n = 1'b0;
        if (i_imem_ready) begin
          pc_n    = redirect ? target : pend;
          state_n = FETCH;
        end else if (redirect) begin
          pend_n = target;
        end else begin
          state_n = DROP;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_n    = target;
          valid_n = 1'b0;
          state_n = FETCH;
        end else if (!i_stall) begin
          instr_n = hold;
          pc4_n   = pc_plus4;
          valid_n = 1'b1;
          pc_n    = pc_plus4;
          state_n = FETCH;
        end else begin
          state_n = HOLD;
        end
      end
      default: begin
        state_n = BOOT;
      end
    endcase
    // Kill wins over any IF/ID load in every state.
    if (i_kill1) begin
      instr_n = o_ifid_instr;
      pc4_n   = o_ifid_pc4;
      valid_n = 1'b0;
    end else begin
      valid_n = valid_n;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      pend         <= 32'h0000_0000;
      hold         <= 32'h0000_0000;
      o_ifid_instr <= 32'h0000_0000;
      o_ifid_pc4   <= 32'h0000_0000;
      o_ifid_valid <= 1'b0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      pend         <= pend_n;
      hold         <= hold_n;
      o_ifid_instr <= instr_n;
      o_ifid_pc4   <= pc4_n;
      o_ifid_valid <= valid_n;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Table-driven bench for fetch_unit: per-cycle vectors of inputs and expected
// outputs, plus hand sequences for reset-in-DROP, kill-only and PC wrap.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pc_src;
  logic        kill1;
  logic [31:0] jump_target, branch_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_data;
  logic [31:0] ifid_instr, ifid_pc4;
  logic        ifid_valid;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] X = 32'hDEAD_BEE0;

  always #5 clk = ~clk;

  // Memory returns the inverted address so instr and pc4 can never alias.
  assign imem_data = ~imem_addr;

  fetch_unit #(.RESET_PC(32'h0040_0000)) dut (
    .i_clk(clk), .i_rst(rst), .i_pc_src(pc_src), .i_kill1(kill1),
    .i_jump_target(jump_target), .i_branch_target(branch_target),
    .i_stall(stall), .o_imem_req(imem_req), .o_imem_addr(imem_addr),
    .i_imem_ready(imem_ready), .i_imem_data(imem_data),
    .o_ifid_instr(ifid_instr), .o_ifid_pc4(ifid_pc4), .o_ifid_valid(ifid_valid)
  );

  typedef struct {
    logic [1:0]  ps;
    logic        kill;
    logic [31:0] jt;
    logic [31:0] bt;
    logic        st;
    logic        rd;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input logic [1:0] ps, input logic k,
                              input logic [31:0] jt, input logic [31:0] bt,
                              input logic st, input logic rd, input logic er,
                              input logic [31:0] ea, input logic ev,
                              input logic [31:0] ei, input logic [31:0] ep);
    vec_t v;
    v.ps = ps; v.kill = k; v.jt = jt; v.bt = bt; v.st = st; v.rd = rd;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_instr = ei; v.e_pc4 = ep;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    //            ps     k     jt            bt            st    rd    req   addr          v     instr          pc4
    vecs[0]  = mk(2'b00, 1'b0, X,            X,            1'b0, 1'b1, 1'b0, 32'h0040_0000, 1'b0, 32'h0,          32'h0);
    vecs[1]  = mk(2'b00, 1'b0, X,            X,            1'b0, 1'b1, 1'b1, 32'h0040_0000, 1'b0, 32'h0,          32'h0);
    vecs[2]  = mk(2'b00, 1'b0, X,            X,            1'b0, 1'b1, 1'b1, 32'h0040_0004, 1'b1, ~32'h0040_0000, 32'h0040_0004);
    vecs[3]  = mk(2'b01, 1'b1, 32'h0040_0103, X,           1'b0, 1'b1, 1'b1, 32'h0040_0008, 1'b1, ~32'h0040_0004, 32'h0040_0008);
    vecs[4]  = mk(2'b00, 1'b0, X,            X,            1'b0, 1'b1, 1'b1, 32'h0040_0100, 1'b0, 32'h0,          32'h0);
    vecs[5]  = mk(2'b01, 1'b1, 32'h0000_0010, X,           1'b0, 1'b1, 1'b1, 32'h0040_0104, 1'b1, ~32'h0040_0100, 32'h0040_0104);
    vecs[6]  = mk(2'b11, 1'b0, X,            32'h0000_0200, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 1'b0, 32'h0,          32'h0);
    vecs[7]  = mk(2'b10, 1'b0, X,            32'h0000_0300, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 1'b0, 32'h0,          32'h0);
    vecs[8]  = mk(2'b00, 1'b0, X,            X,            1'b0, 1'b0, 1'b1, 32'h0000_0010, 1'b0, 32'h0,          32'h0);
    vecs[9]  = mk(2'b00, 1'b0, X,            X,            1'b0, 1'b1, 1'b1, 32'h0000_0010, 1'b0, 32'h0,          32'h0);
    vecs[10] = mk(2'b00, 1'b0, X,            X,            1'b0, 1'b1, 1'b1, 32'h0000_0300, 1'b0, 32'h0,          32'h0);
    vecs[11] = mk(2'b01, 1'b1, 32'h0000_001C, X,           1'b0, 1'b1, 1'b1, 32'h0000_0304, 1'b1, ~32'h0000_0300, 32'h0000_0304);
    vecs[12] = mk(2'b00, 1'b0, X,            X,            1'b0, 1'b1, 1'b1, 32'h0000_001C, 1'b0, 32'h0,          32'h0);
    vecs[13] = mk(2'b00, 1'b0, X,            X,            1'b1, 1'b1, 1'b1, 32'h0000_0020, 1'b1, ~32'h0000_001C, 32'h0000_0020);
    vecs[14] = mk(2'b00, 1'b0, X,            X,            1'b1, 1'b1, 1'b0, 32'h0000_0020, 1'b1, ~32'h0000_001C, 32'h0000_0020);
    vecs[15] = mk(2'b00, 1'b0, X,            X,            1'b0, 1'b1, 1'b0, 32'h0000_0020, 1'b1, ~32'h0000_001C, 32'h0000_0020);
    vecs[16] = mk(2'b00, 1'b0, X,            X,            1'b1, 1'b1, 1'b1, 32'h0000_0024, 1'b1, ~32'h0000_0020, 32'h0000_0024);
    vecs[17] = mk(2'b01, 1'b1, 32'h0000_0400, X,           1'b1, 1'b1, 1'b0, 32'h0000_0024, 1'b1, ~32'h0000_0020, 32'h0000_0024);
    vecs[18] = mk(2'b10, 1'b0, X,            32'h0000_0500, 1'b0, 1'b0, 1'b1, 32'h0000_0400, 1'b0, 32'h0,          32'h0);
    vecs[19] = mk(2'b00, 1'b0, X,            X,            1'b0, 1'b0, 1'b1, 32'h0000_0400, 1'b0, 32'h0,          32'h0);

    rst = 1'b1; pc_src = 2'b00; kill1 = 1'b0; jump_target = X; branch_target = X;
    stall = 1'b0; imem_ready = 1'b0;
    step();
    step();
    chk("reset_req",   {31'd0, imem_req},   32'd0);
    chk("reset_valid", {31'd0, ifid_valid}, 32'd0);
    chk("reset_instr", ifid_instr,          32'h0);
    chk("reset_pc4",   ifid_pc4,            32'h0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      pc_src = vecs[i].ps; kill1 = vecs[i].kill;
      jump_target = vecs[i].jt; branch_target = vecs[i].bt;
      stall = vecs[i].st; imem_ready = vecs[i].rd;
      #1;
      chk($sformatf("v%0d_req", i),   {31'd0, imem_req},   {31'd0, vecs[i].e_req});
      chk($sformatf("v%0d_addr", i),  imem_addr,           vecs[i].e_addr);
      chk($sformatf("v%0d_valid", i), {31'd0, ifid_valid}, {31'd0, vecs[i].e_valid});
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d_instr", i), ifid_instr, vecs[i].e_instr);
        chk($sformatf("v%0d_pc4", i),   ifid_pc4,   vecs[i].e_pc4);
      end
      step();
    end

    // Still in DROP at 0x400; reset must abandon it.
    pc_src = 2'b00; kill1 = 1'b0; stall = 1'b0; imem_ready = 1'b0;
    chk("drop_req",  {31'd0, imem_req}, 32'd1);
    chk("drop_addr", imem_addr,         32'h0000_0400);
    rst = 1'b1;
    step();
    chk("rst_drop_req",   {31'd0, imem_req},   32'd0);
    chk("rst_drop_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rst_drop_addr",  imem_addr,           32'h0040_0000);
    chk("rst_drop_instr", ifid_instr,          32'h0);
    rst = 1'b0; imem_ready = 1'b1;
    step();
    chk("restart_req",  {31'd0, imem_req}, 32'd1);
    chk("restart_addr", imem_addr,         32'h0040_0000);

    // Kill alone: pc advances but IF/ID is not made valid.
    kill1 = 1'b1;
    step();
    chk("killonly_addr",  imem_addr,           32'h0040_0004);
    chk("killonly_valid", {31'd0, ifid_valid}, 32'd0);

    // Jump to an unaligned top-of-memory target, then wrap on PC+4.
    pc_src = 2'b01; kill1 = 1'b1; jump_target = 32'hFFFF_FFFF;
    step();
    chk("wrap_addr",  imem_addr,           32'hFFFF_FFFC);
    chk("wrap_valid", {31'd0, ifid_valid}, 32'd0);
    pc_src = 2'b00; kill1 = 1'b0; jump_target = X;
    step();
    chk("wrap_next_addr", imem_addr,           32'h0000_0000);
    chk("wrap_ifid_valid", {31'd0, ifid_valid}, 32'd1);
    chk("wrap_ifid_instr", ifid_instr,          32'h0000_0003);
    chk("wrap_ifid_pc4",   ifid_pc4,            32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
